// File: rtl/key_pkg.sv
// Shared types and timing defaults for the key repeat filter.
package key_pkg;

    // Width of the debounce counter and the hold/repeat timer.
    localparam int KCW = 8;

    // Default timing, counted in clk190hz cycles.
    localparam int DEF_DEBOUNCE      = 4;   // about 21 ms of stable level
    localparam int DEF_HOLD_DELAY    = 95;  // about 0.5 s before the first repeat
    localparam int DEF_REPEAT_PERIOD = 19;  // about 0.1 s between repeats

    // Per-channel press state.
    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } key_state_t;

    // Counter values are loaded as N-1 so that the event fires on the Nth edge.
    function automatic logic [KCW-1:0] cycles_to_load(input int n);
        return KCW'(n - 1);
    endfunction

endpackage

// File: rtl/key_channel.sv
// One button channel: two-flop synchroniser, level debouncer and
// press/auto-repeat pulse generator.
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE      = DEF_DEBOUNCE,
    parameter int HOLD_DELAY    = DEF_HOLD_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int REPEAT_EN     = 1
) (
    input  logic clk190hz,
    input  logic rst,
    input  logic key_raw,
    output logic pulse,
    output logic held
);

    localparam logic [KCW-1:0] DB_LAST   = cycles_to_load(DEBOUNCE);
    localparam logic [KCW-1:0] HOLD_LOAD = cycles_to_load(HOLD_DELAY);
    localparam logic [KCW-1:0] REP_LOAD  = cycles_to_load(REPEAT_PERIOD);

    logic           s1;
    logic           s2;
    logic           stable;
    logic [KCW-1:0] db_cnt;

    key_state_t     state;
    key_state_t     state_nx;
    logic [KCW-1:0] timer;
    logic [KCW-1:0] timer_nx;
    logic           pulse_q;
    logic           pulse_nx;
    logic           armed;
    logic           armed_nx;

    // Bring the asynchronous button level into the clock domain.
    always_ff @(posedge clk190hz) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= key_raw;
            s2 <= s1;
        end
    end

    // Accept a new level only after it has persisted DEBOUNCE cycles.
    always_ff @(posedge clk190hz) begin
        if (rst) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (s2 == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            stable <= s2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Press state, timer and the registered pulse.
    always_ff @(posedge clk190hz) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            pulse_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            pulse_q <= pulse_nx;
            armed   <= armed_nx;
        end
    end

    // Release always wins; otherwise pulse on press and on each timer expiry.
    // 'armed' remembers a press already reported when auto-repeat is off.
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        pulse_nx = 1'b0;
        armed_nx = armed;
        if (!stable) begin
            state_nx = IDLE;
            timer_nx = '0;
            armed_nx = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!armed) begin
                        pulse_nx = 1'b1;
                        if (REPEAT_EN != 0) begin
                            state_nx = HOLD;
                            timer_nx = HOLD_LOAD;
                        end else begin
                            armed_nx = 1'b1;
                        end
                    end
                end
                HOLD, REPEAT: begin
                    if (timer == '0) begin
                        pulse_nx = 1'b1;
                        timer_nx = REP_LOAD;
                        state_nx = REPEAT;
                    end else begin
                        timer_nx = timer - 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    timer_nx = '0;
                end
            endcase
        end
    end

    assign pulse = pulse_q;
    assign held  = stable;

endmodule

// File: rtl/key_repeat_filter.sv
// Multi-button front end: one independent key_channel per button.
module key_repeat_filter
    import key_pkg::*;
#(
    parameter int KEYS          = 3,
    parameter int DEBOUNCE      = DEF_DEBOUNCE,
    parameter int HOLD_DELAY    = DEF_HOLD_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int REPEAT_EN     = 1
) (
    input  logic            clk190hz,
    input  logic            rst,
    input  logic [KEYS-1:0] key_in,
    output logic [KEYS-1:0] key_pulse,
    output logic [KEYS-1:0] key_held
);

    // Channels share nothing but the clock and reset.
    for (genvar i = 0; i < KEYS; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE      (DEBOUNCE),
            .HOLD_DELAY    (HOLD_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .REPEAT_EN     (REPEAT_EN)
        ) u_ch (
            .clk190hz (clk190hz),
            .rst      (rst),
            .key_raw  (key_in[i]),
            .pulse    (key_pulse[i]),
            .held     (key_held[i])
        );
    end

endmodule

// File: tb/tb_key_repeat_filter.sv
// Bench for key_repeat_filter: two instances (auto-repeat on and off) share
// one stimulus stream; a reference model predicts every cycle's outputs.
module tb_key_repeat_filter;

    localparam int DB = 4;
    localparam int HD = 95;
    localparam int RP = 19;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] key_in = 3'b000;
    logic [2:0] pulse_a, held_a, pulse_b, held_b;

    key_repeat_filter #(.KEYS(3), .DEBOUNCE(DB), .HOLD_DELAY(HD),
                        .REPEAT_PERIOD(RP), .REPEAT_EN(1)) dut_a (
        .clk190hz (clk),
        .rst      (rst),
        .key_in   (key_in),
        .key_pulse(pulse_a),
        .key_held (held_a)
    );

    key_repeat_filter #(.KEYS(3), .DEBOUNCE(DB), .HOLD_DELAY(HD),
                        .REPEAT_PERIOD(RP), .REPEAT_EN(0)) dut_b (
        .clk190hz (clk),
        .rst      (rst),
        .key_in   (key_in),
        .key_pulse(pulse_b),
        .key_held (held_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [5:0] exp_a_q[$];
    logic [5:0] exp_b_q[$];
    int pcnt_a[3];
    int pcnt_b[3];

    // Reference model state: raw sample history, accepted level,
    // length of the current disagreeing run, and cycles held so far.
    logic h1[3];
    logic h2[3];
    logic m_stable[2][3];
    int   m_diff[2][3];
    int   m_run[2][3];
    int   m_ren[2] = '{1, 0};

    task automatic checkOutput(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Predict outputs after the coming edge from the press rules:
    // pulse on the first held cycle, then HD later, then every RP.
    task automatic modelStep(input logic [2:0] k, input logic r,
                             output logic [5:0] ea, output logic [5:0] eb);
        logic [2:0] p [2];
        logic [2:0] hv[2];
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 3; c++) begin
                p[d][c] = 1'b0;
                if (r) begin
                    m_stable[d][c] = 1'b0;
                    m_diff[d][c]   = 0;
                    m_run[d][c]    = 0;
                end else begin
                    if (m_stable[d][c]) begin
                        m_run[d][c]++;
                        if (m_run[d][c] == 1)
                            p[d][c] = 1'b1;
                        else if (m_ren[d] != 0 && m_run[d][c] - 1 >= HD &&
                                 (m_run[d][c] - 1 - HD) % RP == 0)
                            p[d][c] = 1'b1;
                    end else begin
                        m_run[d][c] = 0;
                    end
                    if (h2[c] == m_stable[d][c]) begin
                        m_diff[d][c] = 0;
                    end else begin
                        m_diff[d][c]++;
                        if (m_diff[d][c] == DB) begin
                            m_stable[d][c] = h2[c];
                            m_diff[d][c]   = 0;
                        end
                    end
                end
                hv[d][c] = m_stable[d][c];
            end
        end
        for (int c = 0; c < 3; c++) begin
            h2[c] = r ? 1'b0 : h1[c];
            h1[c] = r ? 1'b0 : k[c];
        end
        ea = {p[0], hv[0]};
        eb = {p[1], hv[1]};
    endtask

    task automatic applyStimulus(input logic [2:0] k, input logic r);
        logic [5:0] ea, eb;
        @(negedge clk);
        key_in = k;
        rst    = r;
        modelStep(k, r, ea, eb);
        exp_a_q.push_back(ea);
        exp_b_q.push_back(eb);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare every cycle's outputs with the queued prediction.
    initial begin
        logic [5:0] ea, eb;
        for (int c = 0; c < 3; c++) begin
            pcnt_a[c] = 0;
            pcnt_b[c] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            if (exp_a_q.size() != 0 && exp_b_q.size() != 0) begin
                ea = exp_a_q.pop_front();
                eb = exp_b_q.pop_front();
                checkOutput("cycle_a", int'({pulse_a, held_a}), int'(ea));
                checkOutput("cycle_b", int'({pulse_b, held_b}), int'(eb));
                for (int c = 0; c < 3; c++) begin
                    pcnt_a[c] += int'(pulse_a[c]);
                    pcnt_b[c] += int'(pulse_b[c]);
                end
            end
        end
    end

    // Directed scenarios, then randomized traffic.
    initial begin
        int base;
        int base_b;
        logic [2:0] lvl;
        int left[3];

        for (int c = 0; c < 3; c++) begin
            h1[c] = 1'b0;
            h2[c] = 1'b0;
        end

        repeat (3) applyStimulus(3'b000, 1'b1);
        @(posedge clk); #1;
        checkOutput("reset_pulse", int'(pulse_a), 0);
        checkOutput("reset_held", int'(held_a), 0);

        // First press latency on key 0.
        for (int e = 1; e <= 10; e++) begin
            applyStimulus(3'b001, 1'b0);
            @(posedge clk); #1;
            checkOutput("t1_held0", int'(held_a[0]), int'(e >= 6));
            checkOutput("t1_pulse", int'(pulse_a), (e == 7) ? 1 : 0);
        end
        repeat (12) applyStimulus(3'b000, 1'b0);

        // Glitch on key 1, then a valid short press.
        base = pcnt_a[1];
        repeat (3) applyStimulus(3'b010, 1'b0);
        repeat (10) applyStimulus(3'b000, 1'b0);
        settle();
        checkOutput("glitch_cnt", pcnt_a[1] - base, 0);
        base = pcnt_a[1];
        repeat (5) applyStimulus(3'b010, 1'b0);
        repeat (12) applyStimulus(3'b000, 1'b0);
        settle();
        checkOutput("short_press_cnt", pcnt_a[1] - base, 1);

        // Long hold on key 2.
        base   = pcnt_a[2];
        base_b = pcnt_b[2];
        repeat (300) applyStimulus(3'b100, 1'b0);
        repeat (20) applyStimulus(3'b000, 1'b0);
        settle();
        checkOutput("long_hold_cnt", pcnt_a[2] - base, 12);
        checkOutput("long_hold_cnt_norep", pcnt_b[2] - base_b, 1);

        // Release so the level drops one cycle before the first repeat.
        base = pcnt_a[0];
        repeat (95) applyStimulus(3'b001, 1'b0);
        repeat (20) applyStimulus(3'b000, 1'b0);
        settle();
        checkOutput("early_release_cnt", pcnt_a[0] - base, 1);
        for (int e = 1; e <= 8; e++) begin
            applyStimulus(3'b001, 1'b0);
            @(posedge clk); #1;
            checkOutput("repress_pulse", int'(pulse_a), (e == 7) ? 1 : 0);
        end
        repeat (15) applyStimulus(3'b000, 1'b0);

        // Reset during REPEAT with the key still held.
        repeat (130) applyStimulus(3'b001, 1'b0);
        applyStimulus(3'b001, 1'b1);
        @(posedge clk); #1;
        checkOutput("midrst_pulse", int'(pulse_a), 0);
        checkOutput("midrst_held", int'(held_a), 0);
        for (int e = 1; e <= 8; e++) begin
            applyStimulus(3'b001, 1'b0);
            @(posedge clk); #1;
            checkOutput("postrst_pulse", int'(pulse_a), (e == 7) ? 1 : 0);
        end
        repeat (15) applyStimulus(3'b000, 1'b0);

        // Held key with 2-cycle bounces: one pulse when repeat is off.
        base_b = pcnt_b[0];
        for (int i = 0; i < 500; i++) begin
            applyStimulus((i >= 10 && i % 25 >= 23) ? 3'b000 : 3'b001, 1'b0);
            if (i >= 6) begin
                @(posedge clk); #1;
                checkOutput("bounce_held_b", int'(held_b[0]), 1);
            end
        end
        repeat (20) applyStimulus(3'b000, 1'b0);
        settle();
        checkOutput("bounce_cnt_b", pcnt_b[0] - base_b, 1);

        // Random traffic with occasional resets.
        lvl = 3'b000;
        for (int c = 0; c < 3; c++) left[c] = 1;
        for (int i = 0; i < 2500; i++) begin
            for (int c = 0; c < 3; c++) begin
                left[c]--;
                if (left[c] <= 0) begin
                    lvl[c]  = ~lvl[c];
                    left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 160))
                                                          : int'($urandom_range(1, 8));
                end
            end
            applyStimulus(lvl, ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
        end
        repeat (20) applyStimulus(3'b000, 1'b0);
        settle();
        checkOutput("queue_drained", exp_a_q.size() + exp_b_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
